// File: rtl/mprj_io_cfg_xmit_pkg.sv
// Shared types and sizing helpers for the GPIO pad
// configuration transmitter.
package mprj_cfg_pkg;

    localparam int MPRJ_IO_PADS   = 38;
    localparam int MPRJ_IO_PADS_1 = 19;
    localparam int CFG_BITS_DEF   = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_FETCH_A,
        S_FETCH_D,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LOAD,
        S_DONE
    } cfg_state_t;

    // Both chains shift in lockstep, so the longer one sets the slot count.
    function automatic int calc_slots(
        input int total,
        input int area1
    );
        return (area1 > total - area1) ? area1 : total - area1;
    endfunction

endpackage

// File: rtl/mprj_io_cfg_xmit_if.sv
// Configuration-store read port: two addresses out,
// two words back one cycle later.
interface mprj_io_cfg_xmit_if #(
    parameter int TOTAL_PADS = 38,
    parameter int CFG_BITS   = 13
);
    localparam int AW = $clog2(TOTAL_PADS);

    logic [AW-1:0]       cfg_addr1;
    logic [AW-1:0]       cfg_addr2;
    logic [CFG_BITS-1:0] cfg_data1;
    logic [CFG_BITS-1:0] cfg_data2;

    modport master (
        output cfg_addr1,
        output cfg_addr2,
        input  cfg_data1,
        input  cfg_data2
    );

    modport slave (
        input  cfg_addr1,
        input  cfg_addr2,
        output cfg_data1,
        output cfg_data2
    );

endinterface

// File: rtl/mprj_io_cfg_xmit_tick.sv
// Phase counter 0..CLK_DIV-1 with a pulse on the last
// phase; idles at zero whenever run is low.
module mprj_cfg_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mprj_io_cfg_xmit.sv
// Shifts per-pad GPIO control words out on two serial chains, then loads.
// Optional chain-reset phase before the first fetch: MPRJ_CFG_SERIAL_RESET_EN.
module mprj_io_cfg_xmit
    import mprj_cfg_pkg::*;
#(
    parameter int TOTAL_PADS = MPRJ_IO_PADS,
    parameter int AREA1PADS  = MPRJ_IO_PADS_1,
    parameter int CFG_BITS   = CFG_BITS_DEF,
    parameter int CLK_DIV    = 4
) (
    input  logic wb_clk_i,
    input  logic wb_rstn_i,
    input  logic start,
    output logic busy,
    output logic done,
    mprj_io_cfg_xmit_if.master cfg,
    output logic serial_clock,
    output logic serial_load,
    output logic serial_resetn,
    output logic serial_data_1,
    output logic serial_data_2
);
    localparam int SLOTS = calc_slots(TOTAL_PADS, AREA1PADS);
    localparam int D1    = SLOTS - AREA1PADS;
    localparam int D2    = SLOTS - (TOTAL_PADS - AREA1PADS);
    localparam int AW    = $clog2(TOTAL_PADS);
    localparam int SW    = $clog2(SLOTS + 1);
    localparam int BW    = $clog2(CFG_BITS + 1);
    localparam int A2_0  = (AREA1PADS < TOTAL_PADS) ?
                           AREA1PADS : TOTAL_PADS - 1;

    cfg_state_t          state, nxt;
    logic                run, tick, half;
    logic [SW-1:0]       slot;
    logic [BW-1:0]       bitc;
    logic [CFG_BITS-1:0] sr1, sr2;
    logic [AW-1:0]       addr1, addr2;
    logic                last_bit, last_slot;
    logic                dummy1, dummy2;

    assign run = (state == S_RST) || (state == S_SHIFT_LO) ||
                 (state == S_SHIFT_HI) || (state == S_LOAD);

    mprj_cfg_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (wb_clk_i),
        .rst_n (wb_rstn_i),
        .run   (run),
        .tick  (tick)
    );

    assign last_bit  = (bitc == '0);
    assign last_slot = (slot == SW'(SLOTS - 1));
    // Short chains lead with dummy slots so their real words land at the far end.
    assign dummy1    = int'(slot) < D1;
    assign dummy2    = int'(slot) < D2;

    assign cfg.cfg_addr1 = addr1;
    assign cfg.cfg_addr2 = addr2;
    assign serial_data_1 = sr1[CFG_BITS-1];
    assign serial_data_2 = sr2[CFG_BITS-1];

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt           = state;
        busy          = 1'b1;
        done          = 1'b0;
        serial_clock  = 1'b0;
        serial_load   = 1'b0;
        serial_resetn = 1'b1;
        unique case (state)
`ifdef MPRJ_CFG_SERIAL_RESET_EN
            S_IDLE: begin
                busy = 1'b0;
                if (start) nxt = S_RST;
            end
            S_RST: begin
                serial_resetn = 1'b0;
                if (tick && half) nxt = S_FETCH_A;
            end
`else
            S_IDLE: begin
                busy = 1'b0;
                if (start) nxt = S_FETCH_A;
            end
`endif
            S_FETCH_A: nxt = S_FETCH_D;
            S_FETCH_D: nxt = S_SHIFT_LO;
            S_SHIFT_LO: begin
                if (tick) nxt = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                serial_clock = 1'b1;
                if (tick) begin
                    if (!last_bit)       nxt = S_SHIFT_LO;
                    else if (!last_slot) nxt = S_FETCH_A;
                    else                 nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                serial_load = 1'b1;
                if (tick && half) nxt = S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: begin
                busy = 1'b0;
                nxt  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            half  <= 1'b0;
            slot  <= '0;
            bitc  <= '0;
            sr1   <= '0;
            sr2   <= '0;
            addr1 <= '0;
            addr2 <= '0;
        end else begin
            // LOAD and RST span two tick periods; half marks the second.
            half <= (state == S_RST || state == S_LOAD) ? half ^ tick : 1'b0;
            if (state == S_IDLE && start) begin
                slot  <= '0;
                addr1 <= AW'(AREA1PADS - 1);
                addr2 <= AW'(A2_0);
            end
            if (state == S_FETCH_D) begin
                sr1  <= dummy1 ? '0 : cfg.cfg_data1;
                sr2  <= dummy2 ? '0 : cfg.cfg_data2;
                bitc <= BW'(CFG_BITS - 1);
            end
            if (state == S_SHIFT_HI && tick) begin
                if (!last_bit) begin
                    sr1  <= sr1 << 1;
                    sr2  <= sr2 << 1;
                    bitc <= bitc - 1'b1;
                end else if (!last_slot) begin
                    slot <= slot + 1'b1;
                    if (!dummy1) addr1 <= addr1 - 1'b1;
                    if (!dummy2) addr2 <= addr2 + 1'b1;
                end
            end
        end
    end

endmodule
